// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive-side controller.
package uart_pkg;

  localparam int unsigned UART_RX_DEPTH   = 16;
  localparam int unsigned UART_RX_TIMEOUT = 4096;

  // Read-side handshake sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    POP,
    ACK
  } rx_ctrl_state_e;

endpackage

// File: rtl/uart_rx_timeout.sv
// Idle timer for the receive FIFO: counts clocks with data sitting in the FIFO and no
// traffic, and raises a flag once the FIFO has been idle for TIMEOUT_CYCLES clocks.
module uart_rx_timeout
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = UART_RX_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic nonempty,
  output logic timeout_flag
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          idle;

  // Next-state for the saturating idle counter and the timeout flag.
  always_comb begin
    idle   = nonempty & ~push & ~pop;
    cnt_d  = cnt_q;
    flag_d = flag_q;

    if (!idle) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CW'(1);
    end

    // A push restarts the count but leaves an already raised flag alone.
    if (pop || !nonempty) begin
      flag_d = 1'b0;
    end else if (idle && (cnt_d == CntMax)) begin
      flag_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_flag = flag_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive FIFO controller: gates receiver bytes into the FIFO, serves CPU reads
// over a 4-phase handshake, mirrors the FIFO level and generates the receive interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH          = UART_RX_DEPTH,
  parameter int unsigned CNT_W          = $clog2(DEPTH) + 1,
  parameter int unsigned TIMEOUT_CYCLES = UART_RX_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  // Receiver side
  input  logic             rx_byte_valid,
  input  logic [7:0]       rx_byte,
  input  logic             rx_frame_err,
  // FIFO side
  output logic             rx_fifo_wr_en,
  output logic [7:0]       rx_fifo_data,
  output logic             rx_fifo_rd_en,
  input  logic             rx_fifo_full,
  input  logic             rx_fifo_empty,
  input  logic [7:0]       rx_data,
  // CPU read handshake
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  // Status and interrupt
  input  logic [CNT_W-1:0] thresh,
  input  logic             irq_en,
  input  logic             clr_status,
  output logic [CNT_W-1:0] level,
  output logic             overflow_sticky,
  output logic             frame_err_sticky,
  output logic             rx_irq
);

  rx_ctrl_state_e state_q, state_d;

  logic             rd_ack_q, rd_ack_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             irq_q, irq_d;

  logic push;
  logic pop;
  logic ovf_evt;
  logic ferr_evt;
  logic thresh_hit;
  logic timeout_flag;

  // Write path and FIFO strobes; both strobes are held low while reset is asserted.
  always_comb begin
    rx_fifo_data  = rx_byte;
    rx_fifo_wr_en = ~reset & rx_byte_valid & ~rx_frame_err & ~rx_fifo_full;
    rx_fifo_rd_en = ~reset & (state_q == POP);
    push          = rx_fifo_wr_en;
    pop           = rx_fifo_rd_en & ~rx_fifo_empty;
    // Full is judged before any same-cycle pop, so a pop does not rescue the byte.
    ovf_evt       = rx_byte_valid & ~rx_frame_err & rx_fifo_full;
    ferr_evt      = rx_byte_valid & rx_frame_err;
  end

  // Read handshake sequencing and captured read data.
  always_comb begin
    state_d    = state_q;
    rd_ack_d   = rd_ack_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;

    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (!rx_fifo_empty) begin
            rd_data_d  = rx_data;
            rd_valid_d = 1'b1;
            state_d    = POP;
          end else begin
            rd_data_d  = 8'h00;
            rd_valid_d = 1'b0;
            rd_ack_d   = 1'b1;
            state_d    = ACK;
          end
        end
      end
      POP: begin
        rd_ack_d = 1'b1;
        state_d  = ACK;
      end
      ACK: begin
        if (!rd_req) begin
          rd_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        rd_ack_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Level tracking, sticky flags and interrupt request next-state.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase

    // Set events beat a simultaneous clear.
    ovf_d  = clr_status ? 1'b0 : ovf_q;
    ferr_d = clr_status ? 1'b0 : ferr_q;
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end
    if (ferr_evt) begin
      ferr_d = 1'b1;
    end

    thresh_hit = (thresh != '0) && (level_q >= thresh);
    irq_d      = irq_en & (thresh_hit | timeout_flag | ovf_q);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ack_q   <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ack_q   <= rd_ack_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
      irq_q      <= irq_d;
    end
  end

  uart_rx_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .nonempty     (level_q != '0),
    .timeout_flag (timeout_flag)
  );

  assign rd_ack           = rd_ack_q;
  assign rd_data          = rd_data_q;
  assign rd_valid         = rd_valid_q;
  assign level            = level_q;
  assign overflow_sticky  = ovf_q;
  assign frame_err_sticky = ferr_q;
  assign rx_irq           = irq_q;

endmodule
